mdc_clk_gen: RTL
================

// Module: mdc_clk_gen
// PURPOSE
//  Parametrised MDC clock/reset generator; successor to the fixed /100 divider.
//  Derives MDC_Clk from AXI_Clk with a run-time programmable half-period.
//  Gates MDC glitch-free and emits rise/fall strobes so MDIO logic runs on AXI_Clk.
//  Produces MDC_Rst stretched over a set count of MDC periods; sits in eth_top, drives the PHY MDC pin.
// PARAMETERS
//  DIV_W          8   width of half-period count
//  DEFAULT_HALF   50  half-period (AXI_Clk cycles) after reset; 50 -> 1 MHz from 100 MHz
//  MIN_HALF       2   smallest accepted half-period
//  RST_MDC_CYC    4   MDC rising edges MDC_Rst is held after AXI_Rstn release (>=1)
// PORTS
//  AXI_Clk       in   1      sole clock
//  AXI_Rstn      in   1      synchronous, active-low reset
//  Div_Half      in   DIV_W  requested half-period, AXI_Clk cycles
//  Div_Load      in   1      1-cycle pulse: request Div_Half
//  Clk_En        in   1      level: 1 = run MDC, 0 = park MDC high
//  Div_Err       out  1      1-cycle pulse: Div_Load rejected (Div_Half < MIN_HALF)
//  MDC_Clk       out  1      registered MDC output to PHY
//  MDC_Rise_Stb  out  1      1-cycle pulse, first cycle MDC_Clk shows 1 after 0
//  MDC_Fall_Stb  out  1      1-cycle pulse, first cycle MDC_Clk shows 0 after 1
//  MDC_Rst       out  1      active-high reset for MDC-side logic
//  MDC_Active    out  1      1 when state is RST or RUN or STOP
// BEHAVIOUR
//  Reset (AXI_Rstn=0 at edge): MDC_Clk=1, strobes=0, Div_Err=0, MDC_Rst=1, MDC_Active=0.
//  Reset also sets: cnt=0, rHalf=rPend=DEFAULT_HALF, state=RST, rstcnt=0.
//  Assert AXI_Rstn mid-period: above values apply next edge; no partial phase is kept.
//  Divider: cnt counts 0..rHalf-1 while in RST/RUN/STOP. At cnt==rHalf-1 ("term"), cnt->0.
//  At term MDC_Clk toggles unless the STOP rule blocks it. Each phase is exactly rHalf cycles.
//  Div_Load: if Div_Half>=MIN_HALF, rPend<=Div_Half. Otherwise Div_Err=1 next cycle and rPend is unchanged.
//  rHalf<=rPend only at a term that makes MDC 0->1 (period start) or on IDLE->RUN.
//  A load during a period never alters that period. A later Div_Load overwrites rPend (last wins).
//  Strobes are registered with MDC_Clk: Rise_Stb=1 exactly in the cycle MDC_Clk first reads 1. Likewise Fall_Stb for 0.
//  FSM:
//   RST  : divider free-runs, Clk_En ignored. rstcnt++ on each Rise_Stb.
//          At rstcnt==RST_MDC_CYC: MDC_Rst<=0, then go RUN if Clk_En else STOP.
//   IDLE : MDC_Clk=1, cnt=0, no strobes. Clk_En=1 -> RUN; rHalf<=rPend.
//          First falling edge follows rHalf cycles later.
//   RUN  : Clk_En=0 -> STOP (no effect on the current phase).
//   STOP : continue counting. Clk_En=1 -> RUN, no disturbance.
//          At term with MDC=0: toggle to 1 (Rise_Stb), go IDLE. At term with MDC=1: no toggle, no strobe, go IDLE.
//          High and low phases are never shortened; no glitch on the pin.
//  Simultaneous Div_Load and term: the term uses the old rPend; the new value waits for the next period start.
//  Simultaneous Clk_En fall and term in RUN: toggle as RUN, then STOP.
//  MDC_Rst is low outside RST; it deasserts in the same cycle as the Rise_Stb that completes the count.
//  Latency: Clk_En edge -> state change 1 cycle.
// TESTING
//  1 Release reset, Clk_En=0: MDC period 100 cycles (50/50).
//    Exactly 4 Rise_Stb, then MDC_Rst=0 on the 4th, then STOP->IDLE, MDC_Clk parked 1.
//  2 Clk_En=1 steady: 1000 cycles give 10 Rise_Stb and 10 Fall_Stb, alternating.
//    Each strobe coincides with the MDC_Clk change.
//  3 Div_Half=10 + Div_Load mid-low-phase: current period stays 100.
//    Next period 20 cycles (10/10). Div_Half=1: Div_Err pulse, period unchanged.
//  4 Clk_En 1->0 at cnt=5 of high phase: high lasts full 50, no toggle, IDLE.
//    Clk_En 1->0 in low phase: low completes 50, one Rise_Stb, IDLE.
//  5 Clk_En 0->1->0 within STOP: no glitch, no phase shorter than rHalf.
//  6 AXI_Rstn=0 for 1 cycle mid-RUN: next edge MDC_Clk=1, MDC_Rst=1.
//    Half-period back to 50, RST sequence repeats.

Source files
------------

// File: rtl/mdc_clk_gen.sv
// MDC clock and reset generator: divides AXI_Clk by a programmable half-period, parks
// MDC high without glitches when disabled, and holds MDC_Rst for a set number of MDC periods.
module mdc_clk_gen #(
   parameter int DIV_W        = 8,
   parameter int DEFAULT_HALF = 50,
   parameter int MIN_HALF     = 2,
   parameter int RST_MDC_CYC  = 4
) (
   input  logic             AXI_Clk,
   input  logic             AXI_Rstn,
   input  logic [DIV_W-1:0] Div_Half,
   input  logic             Div_Load,
   input  logic             Clk_En,
   output logic             Div_Err,
   output logic             MDC_Clk,
   output logic             MDC_Rise_Stb,
   output logic             MDC_Fall_Stb,
   output logic             MDC_Rst,
   output logic             MDC_Active
);

   localparam int               RC_W     = $clog2(RST_MDC_CYC + 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_MDC_CYC - 1);
   localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEFAULT_HALF);
   localparam logic [DIV_W-1:0] HALF_MIN = DIV_W'(MIN_HALF);

   typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_RUN, ST_STOP} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] half_q, half_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic [RC_W-1:0]  rstcnt_q, rstcnt_d;
   logic             mdc_q, mdc_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             err_q, err_d;
   logic             mrst_q, mrst_d;
   logic             act_q, act_d;
   logic             term;
   logic             toggle;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      pend_d   = pend_q;
      rstcnt_d = rstcnt_q;
      mdc_d    = mdc_q;
      mrst_d   = mrst_q;
      err_d    = 1'b0;
      toggle   = 1'b0;
      term     = (state_q != ST_IDLE) && (cnt_q == half_q - DIV_W'(1));

      if (Div_Load) begin
         if (Div_Half >= HALF_MIN) pend_d = Div_Half;
         else                      err_d  = 1'b1;
      end

      if (state_q != ST_IDLE) cnt_d = term ? '0 : cnt_q + DIV_W'(1);

      case (state_q)
         ST_RST: toggle = term;
         ST_IDLE: begin
            mdc_d = 1'b1;
            cnt_d = '0;
            if (Clk_En) begin
               state_d = ST_RUN;
               half_d  = pend_q;
            end
         end
         ST_RUN: begin
            toggle = term;
            if (!Clk_En) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (Clk_En) begin
               toggle  = term;
               state_d = ST_RUN;
            end else if (term) begin
               // Only a pending low phase is finished; a high phase simply stays high.
               toggle  = !mdc_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_RST;
      endcase

      if (toggle) mdc_d = !mdc_q;
      rise_d = toggle && !mdc_q;
      fall_d = toggle && mdc_q;

      // A new half-period only takes effect at a period start, using the value held before this edge.
      if (rise_d) half_d = pend_q;

      if ((state_q == ST_RST) && rise_d) begin
         rstcnt_d = rstcnt_q + RC_W'(1);
         if (rstcnt_q == RC_LAST) begin
            mrst_d  = 1'b0;
            state_d = Clk_En ? ST_RUN : ST_STOP;
         end
      end

      act_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge AXI_Clk) begin
      if (!AXI_Rstn) begin
         state_q  <= ST_RST;
         cnt_q    <= '0;
         half_q   <= HALF_RST;
         pend_q   <= HALF_RST;
         rstcnt_q <= '0;
         mdc_q    <= 1'b1;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         err_q    <= 1'b0;
         mrst_q   <= 1'b1;
         act_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         pend_q   <= pend_d;
         rstcnt_q <= rstcnt_d;
         mdc_q    <= mdc_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         err_q    <= err_d;
         mrst_q   <= mrst_d;
         act_q    <= act_d;
      end
   end

   assign Div_Err      = err_q;
   assign MDC_Clk      = mdc_q;
   assign MDC_Rise_Stb = rise_q;
   assign MDC_Fall_Stb = fall_q;
   assign MDC_Rst      = mrst_q;
   assign MDC_Active   = act_q;

endmodule
